// File: rtl/opponent_msg_pkg.sv
// Shared definitions for the opponent message mailbox.
// Channel IDs, payload field offsets, link state type and a saturating
// counter helper used by the top level.
package opponent_msg_pkg;

  // Channel assignments on the receive link
  localparam int CH_PLAYER = 0;
  localparam int CH_GAME   = 1;
  localparam int CH_SYNC   = 2;
  localparam int CH_CTRL   = 3;

  // Payload field offsets (44-bit payload)
  localparam int X_MSB    = 43;
  localparam int X_LSB    = 33;
  localparam int Y_MSB    = 31;
  localparam int Y_LSB    = 21;
  localparam int DIR_MSB  = 19;
  localparam int DIR_LSB  = 11;
  localparam int GAME_MSB = 7;
  localparam int GAME_LSB = 5;
  localparam int RST_BIT  = 3;

  typedef enum logic {
    LINK_DOWN = 1'b0,
    LINK_UP   = 1'b1
  } link_state_t;

  // Statistics counters stick at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mailbox_channel.sv
// One mailbox slot: latest payload, written-since-reset bit, fresh flag.
// Ports:
//   clk_in, rstn_in  clock, async active-low reset
//   wr               write a NEW payload (already classified by the top)
//   payload          incoming payload, also used for the duplicate compare
//   consume          reader strobe; clears fresh when fresh is set
//   clr              link dropped: clear fresh, keep data
//   data, fresh      stored payload and fresh flag
//   dup              payload matches stored value of a written slot
//   overrun          this write replaces fresh data the reader never took
module mailbox_channel #(
  parameter int PAYLOAD_W = 44
) (
  input  logic                 clk_in,
  input  logic                 rstn_in,
  input  logic                 wr,
  input  logic [PAYLOAD_W-1:0] payload,
  input  logic                 consume,
  input  logic                 clr,
  output logic [PAYLOAD_W-1:0] data,
  output logic                 fresh,
  output logic                 dup,
  output logic                 overrun
);

  logic written_q;

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      data      <= '0;
      written_q <= 1'b0;
      fresh     <= 1'b0;
    end else begin
      if (wr) begin
        data      <= payload;
        written_q <= 1'b1;
      end
      // wr and clr never coincide: the link only drops in a cycle with no
      // accepted word. wr beats consume so a same-cycle refill stays fresh.
      if (clr)          fresh <= 1'b0;
      else if (wr)      fresh <= 1'b1;
      else if (consume) fresh <= 1'b0;
    end
  end

  assign dup     = written_q && (payload == data);
  assign overrun = wr && fresh && !consume;

endmodule

// File: rtl/opponent_msg_mailbox.sv
// Multi-channel mailbox between the Ethernet receive path and game logic.
// Demuxes words by channel ID, drops invalid/idle words, suppresses
// duplicates, and tracks link liveness with a heartbeat timeout.
// Ports:
//   clk_in, rstn_in   clock, async active-low reset
//   s_axiiv, s_axiid  input word strobe and {channel ID, payload}
//   m_axiov, m_axiod  per-channel fresh flags and latest payloads
//   m_ready           per-channel consume strobes
//   link_up           a word was accepted within TIMEOUT_CYC cycles
//   drop_count        saturating count of dropped words
//   overrun_count     saturating count of unconsumed data overwritten
module opponent_msg_mailbox
  import opponent_msg_pkg::*;
#(
  parameter int PAYLOAD_W   = 44,
  parameter int NUM_CH      = 4,
  parameter int TIMEOUT_CYC = 3_250_000,
  parameter bit DROP_ZERO   = 1'b1,
  localparam int CH_W       = $clog2(NUM_CH),
  localparam int DATA_W     = CH_W + PAYLOAD_W
) (
  input  logic                        clk_in,
  input  logic                        rstn_in,
  input  logic                        s_axiiv,
  input  logic [DATA_W-1:0]           s_axiid,
  output logic [NUM_CH-1:0]           m_axiov,
  output logic [NUM_CH*PAYLOAD_W-1:0] m_axiod,
  input  logic [NUM_CH-1:0]           m_ready,
  output logic                        link_up,
  output logic [15:0]                 drop_count,
  output logic [15:0]                 overrun_count
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  logic [CH_W-1:0]      ch_id;
  logic [PAYLOAD_W-1:0] payload;
  logic                 id_ok, is_zero, drop, hb;

  logic [NUM_CH-1:0]                 sel, new_wr, dup_ch, ovr_ch;
  logic [NUM_CH-1:0][PAYLOAD_W-1:0]  data_arr;

  link_state_t      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             clr_all;

  assign ch_id   = s_axiid[DATA_W-1 -: CH_W];
  assign payload = s_axiid[PAYLOAD_W-1:0];

  // With a power-of-two channel count every encodable ID is valid
  if (NUM_CH == (1 << CH_W)) begin : g_id_full
    assign id_ok = 1'b1;
  end else begin : g_id_part
    localparam logic [CH_W-1:0] ID_LIM = CH_W'(NUM_CH);
    assign id_ok = (ch_id < ID_LIM);
  end

  assign is_zero = DROP_ZERO && (payload == '0);
  assign drop    = s_axiiv && (!id_ok || is_zero);
  // DUP and NEW words both prove the far end is alive
  assign hb      = s_axiiv && !drop;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign sel[c]    = hb && (ch_id == CH_W'(c));
    assign new_wr[c] = sel[c] && !dup_ch[c];

    mailbox_channel #(.PAYLOAD_W(PAYLOAD_W)) u_ch (
      .clk_in  (clk_in),
      .rstn_in (rstn_in),
      .wr      (new_wr[c]),
      .payload (payload),
      .consume (m_ready[c]),
      .clr     (clr_all),
      .data    (data_arr[c]),
      .fresh   (m_axiov[c]),
      .dup     (dup_ch[c]),
      .overrun (ovr_ch[c])
    );
  end

  assign m_axiod = data_arr;

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      drop_count    <= '0;
      overrun_count <= '0;
    end else begin
      if (drop)    drop_count    <= sat_inc16(drop_count);
      if (|ovr_ch) overrun_count <= sat_inc16(overrun_count);
    end
  end

  // Link liveness FSM
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q <= LINK_DOWN;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    clr_all = 1'b0;
    case (state_q)
      LINK_DOWN: begin
        timer_d = '0;
        if (hb) state_d = LINK_UP;
      end
      LINK_UP: begin
        if (hb) begin
          timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
          state_d = LINK_DOWN;
          timer_d = '0;
          clr_all = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = LINK_DOWN;
        timer_d = '0;
      end
    endcase
  end

  assign link_up = (state_q == LINK_UP);

endmodule

// File: tb/tb_opponent_msg_mailbox.sv
module tb_opponent_msg_mailbox;
  localparam int PW = 44;
  localparam int NC = 4;
  localparam int TO = 100;
  localparam int DW = 46;

  logic clk_65mhz = 1'b0;
  logic rstn_in   = 1'b0;
  always #5 clk_65mhz = ~clk_65mhz;

  logic             s_axiiv = 1'b0;
  logic [DW-1:0]    s_axiid = '0;
  logic [NC-1:0]    m_axiov;
  logic [NC*PW-1:0] m_axiod;
  logic [NC-1:0]    m_ready = '0;
  logic             link_up;
  logic [15:0]      drop_count, overrun_count;

  // Three-channel build exercises out-of-range channel IDs
  logic           s_axiiv3 = 1'b0;
  logic [DW-1:0]  s_axiid3 = '0;
  logic [2:0]     m_axiov3;
  logic [3*PW-1:0] m_axiod3;
  logic [2:0]     m_ready3 = '0;
  logic           link_up3;
  logic [15:0]    drop_count3, overrun_count3;

  opponent_msg_mailbox #(.PAYLOAD_W(PW), .NUM_CH(NC), .TIMEOUT_CYC(TO), .DROP_ZERO(1'b1)) u_dut (
    .clk_in(clk_65mhz), .rstn_in(rstn_in), .s_axiiv(s_axiiv), .s_axiid(s_axiid),
    .m_axiov(m_axiov), .m_axiod(m_axiod), .m_ready(m_ready), .link_up(link_up),
    .drop_count(drop_count), .overrun_count(overrun_count));

  opponent_msg_mailbox #(.PAYLOAD_W(PW), .NUM_CH(3), .TIMEOUT_CYC(TO), .DROP_ZERO(1'b1)) u_dut3 (
    .clk_in(clk_65mhz), .rstn_in(rstn_in), .s_axiiv(s_axiiv3), .s_axiid(s_axiid3),
    .m_axiov(m_axiov3), .m_axiod(m_axiod3), .m_ready(m_ready3), .link_up(link_up3),
    .drop_count(drop_count3), .overrun_count(overrun_count3));

  int total = 0;
  int bad   = 0;

  // Reference model: mailbox contents and link as the rules describe them
  logic [PW-1:0] st[NC];
  bit            wrt[NC];
  bit            fr[NC];
  int            drops, ovrs, idle;
  bit            up;

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin st[c] = '0; wrt[c] = 0; fr[c] = 0; end
    drops = 0; ovrs = 0; idle = 0; up = 0;
  endtask

  task automatic model_edge(input bit v, input int id, input logic [PW-1:0] pl, input logic [NC-1:0] rdy);
    bit hb = 0;
    bit old_fr[NC];
    for (int c = 0; c < NC; c++) begin
      old_fr[c] = fr[c];
      if (fr[c] && rdy[c]) fr[c] = 0;
    end
    if (v) begin
      if (id >= NC || pl == 0) begin
        if (drops < 65535) drops++;
      end else if (wrt[id] && st[id] == pl) begin
        hb = 1;
      end else begin
        hb = 1;
        if (old_fr[id] && !rdy[id] && ovrs < 65535) ovrs++;
        st[id] = pl; wrt[id] = 1; fr[id] = 1;
      end
    end
    if (hb) begin
      up = 1; idle = 0;
    end else if (up) begin
      idle++;
      if (idle == TO) begin
        up = 0; idle = 0;
        for (int c = 0; c < NC; c++) fr[c] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [NC*PW-1:0] obs, input logic [NC*PW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NC*PW-1:0] ed;
    logic [NC-1:0]    ev;
    for (int c = 0; c < NC; c++) begin ed[c*PW +: PW] = st[c]; ev[c] = fr[c]; end
    chk({tag, ".axiov"}, m_axiov, ev);
    chk({tag, ".axiod"}, m_axiod, ed);
    chk({tag, ".link"},  link_up, up);
    chk({tag, ".drop"},  drop_count, drops);
    chk({tag, ".ovr"},   overrun_count, ovrs);
  endtask

  task automatic step(input bit v, input int id, input logic [PW-1:0] pl, input logic [NC-1:0] rdy, input bit do_chk);
    s_axiiv = v;
    s_axiid = {id[1:0], pl};
    m_ready = rdy;
    @(posedge clk_65mhz);
    model_edge(v, id, pl, rdy);
    #1;
    s_axiiv = 1'b0;
    m_ready = '0;
    if (do_chk) check_all("step");
  endtask

  initial begin
    logic [63:0]   r;
    logic [PW-1:0] pl;
    model_reset();
    #12 rstn_in = 1'b1;
    @(posedge clk_65mhz); #1;
    check_all("reset");

    // Out-of-range ID on the 3-channel build, then a valid word on ch2
    s_axiiv3 = 1'b1; s_axiid3 = {2'd3, 44'h5};
    @(posedge clk_65mhz); #1;
    chk("ch3.bad_id.drop", drop_count3, 16'd1);
    chk("ch3.bad_id.link", link_up3, 1'b0);
    chk("ch3.bad_id.axiov", m_axiov3, 3'b000);
    s_axiid3 = {2'd2, 44'h7};
    @(posedge clk_65mhz); #1;
    s_axiiv3 = 1'b0;
    chk("ch3.ok.axiov", m_axiov3, 3'b100);
    chk("ch3.ok.data", m_axiod3[2*PW +: PW], 44'h7);
    chk("ch3.ok.link", link_up3, 1'b1);
    model_edge(0, 0, '0, '0); model_edge(0, 0, '0, '0);

    // First word, duplicate, consume
    step(1, 1, 44'h123, 4'b0000, 1);
    chk("new.axiov", m_axiov, 4'b0010);
    chk("new.data", m_axiod[PW +: PW], 44'h123);
    chk("new.link", link_up, 1'b1);
    step(1, 1, 44'h123, 4'b0000, 1);
    chk("dup.drop", drop_count, 16'd0);
    step(0, 0, '0, 4'b0010, 1);
    chk("consume.axiov", m_axiov, 4'b0000);
    chk("consume.data", m_axiod[PW +: PW], 44'h123);

    // Zero payloads are idle, not heartbeats
    step(1, 2, '0, 4'b0000, 1);
    step(1, 0, '0, 4'b0000, 1);
    chk("zero.drop", drop_count, 16'd2);

    // Overwrite without consume, then refill with simultaneous consume
    step(1, 0, 44'hA, 4'b0000, 1);
    step(1, 0, 44'hB, 4'b0000, 1);
    chk("ovr.count", overrun_count, 16'd1);
    chk("ovr.data", m_axiod[PW-1:0], 44'hB);
    step(1, 0, 44'hC, 4'b0001, 1);
    chk("refill.fresh", m_axiov[0], 1'b1);
    chk("refill.ovr", overrun_count, 16'd1);

    // Timeout: 99 quiet cycles keep the link, the 100th drops it
    for (int i = 0; i < TO - 1; i++) step(0, 0, '0, '0, 1);
    chk("to99.link", link_up, 1'b1);
    step(0, 0, '0, '0, 1);
    chk("to100.link", link_up, 1'b0);
    chk("to100.axiov", m_axiov, 4'b0000);
    chk("to100.data", m_axiod[PW-1:0], 44'hC);

    // Heartbeat on the expiry cycle keeps the link up
    step(1, 3, 44'h55, '0, 1);
    for (int i = 0; i < TO - 1; i++) step(0, 0, '0, '0, 1);
    step(1, 3, 44'h55, '0, 1);
    chk("hb_expiry.link", link_up, 1'b1);

    // Random traffic with a quiet gap in the middle
    for (int i = 0; i < 500; i++) begin
      r = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: pl = '0;
        1: pl = 44'h1;
        2: pl = 44'h2;
        3: pl = 44'h3;
        default: pl = r[PW-1:0];
      endcase
      if (i >= 200 && i < 310) step(0, 0, '0, 4'($urandom), 1);
      else step($urandom_range(0, 9) < 4, $urandom_range(0, NC - 1), pl, 4'($urandom), 1);
    end

    // Async reset in the middle of the stream
    step(1, 2, 44'h77, '0, 1);
    #2 rstn_in = 1'b0;
    #1;
    chk("arst.axiov", m_axiov, 4'b0000);
    chk("arst.axiod", m_axiod, '0);
    chk("arst.link", link_up, 1'b0);
    chk("arst.drop", drop_count, 16'd0);
    chk("arst.ovr", overrun_count, 16'd0);
    model_reset();
    #1 rstn_in = 1'b1;

    // Drop counter saturation
    for (int i = 0; i < 70000; i++) step(1, $urandom_range(0, NC - 1), '0, '0, 0);
    check_all("sat");
    chk("sat.drop", drop_count, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
